// File: rtl/mux_marshalling_pkg.sv
// Shared definitions for the serializer/deserializer pair.
//   ser_state_t      : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH    : default word width, also used by the deserializer
//   DEFAULT_IDLE_BIT : default serial line level when no word is in flight
package mux_marshalling_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam logic        DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/mux_unmarshalling_if.sv
// Bus between a word producer and the parallel-to-serial converter.
//   data_in     : parallel word (producer -> converter)
//   data_valid  : producer has a word on data_in
//   data_ready  : converter can accept a word this cycle
//   serial_out  : serial bit stream, LSB first
//   frame_start : high while serial_out carries bit 0
//   busy        : high while a word is being shifted out
// Modports: master = producer side, slave = converter side.
interface mux_unmarshalling_if
  import mux_marshalling_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             frame_start;
  logic             busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/mux_unmarshalling.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word over valid/ready and
// shifts it out LSB first, one bit per cycle, with back-to-back frames seamless.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mux_unmarshalling_if.slave (data_in, data_valid, data_ready,
//          serial_out, frame_start, busy)
// Optional feature: define MUX_UNMARSHALLING_PARITY_EN to append an even-parity
// bit (XOR of the word) after the data bits, making each frame WIDTH+1 bits.
module mux_unmarshalling
  import mux_marshalling_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter logic        IDLE_BIT = DEFAULT_IDLE_BIT
) (
  input logic                clk,
  input logic                rst,
  mux_unmarshalling_if.slave bus
);

`ifdef MUX_UNMARSHALLING_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned       CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);

  ser_state_t           state_q;
  // Holds the bits not yet driven; the bit currently on serial_out lives in serial_q.
  logic [FRAME_LEN-1:0] shreg_q;
  // Index of the bit currently on serial_out.
  logic [CNT_W-1:0]     cnt_q;
  logic                 serial_q;
  logic                 frame_start_q;
  logic                 busy_q;

  logic                 last_bit;
  logic                 accept;
  logic [FRAME_LEN-1:0] frame;

`ifdef MUX_UNMARSHALLING_PARITY_EN
  assign frame = {^bus.data_in, bus.data_in};
`else
  assign frame = bus.data_in;
`endif

  assign last_bit       = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  // Held low during reset even though the held state is IDLE.
  assign bus.data_ready = rst && ((state_q == IDLE) || last_bit);
  assign accept         = bus.data_valid && bus.data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      serial_q      <= IDLE_BIT;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else if (accept) begin
      // Bit 0 goes straight to the output register so it appears next cycle.
      state_q       <= SHIFT;
      shreg_q       <= frame >> 1;
      cnt_q         <= '0;
      serial_q      <= frame[0];
      frame_start_q <= 1'b1;
      busy_q        <= 1'b1;
    end else if (state_q == SHIFT) begin
      frame_start_q <= 1'b0;
      if (last_bit) begin
        state_q  <= IDLE;
        shreg_q  <= '0;
        cnt_q    <= '0;
        serial_q <= IDLE_BIT;
        busy_q   <= 1'b0;
      end else begin
        serial_q <= shreg_q[0];
        shreg_q  <= shreg_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.serial_out  = serial_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mux_unmarshalling.sv
// Self-checking bench for mux_unmarshalling: directed table, hand-written
// corner sequences, then randomized traffic against a bit-queue model.
module tb_mux_unmarshalling;
  import mux_marshalling_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef MUX_UNMARSHALLING_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_unmarshalling_if #(.WIDTH(W)) bus ();

  mux_unmarshalling #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_bits;  // exp_bits[i] = serial level i cycles after first bit
    logic         exp_par;
  } vec_t;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } bit_t;

  bit_t   q[$];
  bit_t   cur;
  logic   have_cur;
  logic   acc;
  logic   exp_ready;
  logic [W-1:0] word;
  vec_t   tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_serial"}, bus.serial_out, 0);
    chk({nm, "_fs"}, bus.frame_start, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_ready"}, bus.data_ready, 1);
  endtask

  // Checks one frame starting at the current negedge (bit 0 on the line);
  // returns at the negedge following the last bit.
  task automatic check_frame(input string nm, input logic [W:0] bits);
    for (int i = 0; i < FL; i++) begin
      chk({nm, "_serial"}, bus.serial_out, bits[i]);
      chk({nm, "_fs"}, bus.frame_start, (i == 0));
      chk({nm, "_busy"}, bus.busy, 1);
      chk({nm, "_ready"}, bus.data_ready, (i == FL - 1));
      cycle();
    end
  endtask

  // Presents a word and waits (bounded) for acceptance; returns at bit 0.
  task automatic send(input string nm, input logic [W-1:0] w);
    int waited = 0;
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && waited < 4 * FL) begin
      cycle();
      waited++;
    end
    chk({nm, "_accept_ready"}, bus.data_ready, 1);
    cycle();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0};
    tbl[1] = '{word: 8'h3C, exp_bits: 8'b0011_1100, exp_par: 1'b0};
    tbl[2] = '{word: 8'h00, exp_bits: 8'b0000_0000, exp_par: 1'b0};
    tbl[3] = '{word: 8'hFF, exp_bits: 8'b1111_1111, exp_par: 1'b0};
    tbl[4] = '{word: 8'h01, exp_bits: 8'b0000_0001, exp_par: 1'b1};
    tbl[5] = '{word: 8'h07, exp_bits: 8'b0000_0111, exp_par: 1'b1};
    tbl[6] = '{word: 8'h80, exp_bits: 8'b1000_0000, exp_par: 1'b1};

    acc            = 1'b0;
    have_cur       = 1'b0;
    rst            = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h5A;

    // Reset held with valid high: everything quiet, not ready.
    repeat (3) begin
      @(negedge clk);
      chk("rst_serial", bus.serial_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_fs", bus.frame_start, 0);
      chk("rst_ready", bus.data_ready, 0);
    end
    rst = 1'b1;
    #1;
    chk("rel_ready", bus.data_ready, 1);
    // Word still valid is taken on the first post-reset edge.
    @(posedge clk);
    @(negedge clk);
    bus.data_valid = 1'b0;
    check_frame("rst_word", {^8'h5A, 8'h5A});
    check_idle("rst_word_end");

    // Directed table, each with a short stall afterwards.
    for (int k = 0; k < 7; k++) begin
      send("tbl", tbl[k].word);
      check_frame("tbl", {tbl[k].exp_par, tbl[k].exp_bits});
      repeat (2) begin
        check_idle("tbl_gap");
        cycle();
      end
    end

    // Back-to-back 3C then C3 with valid held high.
    send("b2b", 8'h3C);
    bus.data_in    = 8'hC3;
    bus.data_valid = 1'b1;
    check_frame("b2b_a", {1'b0, 8'b0011_1100});
    bus.data_valid = 1'b0;
    check_frame("b2b_b", {1'b0, 8'b1100_0011});
    check_idle("b2b_end");

    // Stall of 5 idle cycles, then the next word starts right after acceptance.
    repeat (5) begin
      cycle();
      check_idle("stall");
    end
    send("post_stall", 8'h96);
    check_frame("post_stall", {1'b0, 8'b1001_0110});
    check_idle("post_stall_end");

    // Reset during bit 3 of FF.
    send("mid", 8'hFF);
    repeat (3) cycle();
    chk("mid_bit3", bus.serial_out, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_serial", bus.serial_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_fs", bus.frame_start, 0);
    chk("mid_rst_ready", bus.data_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (FL) begin
      cycle();
      check_idle("mid_after");
    end
    send("mid_next", 8'h01);
    check_frame("mid_next", {1'b1, 8'b0000_0001});
    check_idle("mid_next_end");

    // Randomized traffic against a queue-of-bits model.
    q.delete();
    have_cur = 1'b0;
    acc      = 1'b0;
    bus.data_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.data_valid || acc) begin
        bus.data_valid = ($urandom_range(0, 3) != 0);
        bus.data_in    = W'($urandom);
      end
      exp_ready = !have_cur || cur.last;
      acc       = bus.data_valid && exp_ready;
      word      = bus.data_in;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < FL; i++) begin
          q.push_back('{b: (i < W) ? word[i] : ^word, first: (i == 0), last: (i == FL - 1)});
        end
      end
      if (q.size() > 0) begin
        cur      = q.pop_front();
        have_cur = 1'b1;
      end else begin
        have_cur = 1'b0;
      end
      @(negedge clk);
      chk("rnd_serial", bus.serial_out, have_cur ? cur.b : 1'b0);
      chk("rnd_fs", bus.frame_start, have_cur && cur.first);
      chk("rnd_busy", bus.busy, have_cur);
      chk("rnd_ready", bus.data_ready, !have_cur || cur.last);
    end
    bus.data_valid = 1'b0;
    repeat (FL + 1) cycle();
    check_idle("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_unmarshalling.md
Name: mux_unmarshalling

Overview:
- Parallel-to-serial converter, the transmit-side counterpart of the team's 8-bit serial deserializer.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a 1-bit serial line, LSB first, one bit per clk cycle.
- Back-to-back words are sent with no idle gap, so the serial stream is continuous while data is supplied.
- frame_start marks bit 0 of each word, for downstream alignment.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- IDLE_BIT, 1'b0: level driven on serial_out when no word is in flight.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- data_in  input  WIDTH  parallel word; must be held stable while data_valid=1 and not yet accepted.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial bit stream, registered.
- frame_start  output  1  high in the cycle serial_out carries bit 0, registered.
- busy  output  1  high while a word is being shifted out, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - serial_out=IDLE_BIT, frame_start=0, busy=0.
  - data_ready=0 while rst=0; data_ready=1 from the first cycle after release.
- Acceptance occurs on the rising edge where data_valid && data_ready.
- State machine, states IDLE and SHIFT:
  - IDLE: data_ready=1. On acceptance, load data_in into the shift register and go to SHIFT with counter=0.
  - SHIFT: serial_out=shreg[0], frame_start=(counter==0), busy=1. Each cycle shift right by one and increment the counter.
  - data_ready=1 in SHIFT only when counter==WIDTH-1 (last-bit cycle).
  - Acceptance in the last-bit cycle reloads the shift register and stays in SHIFT with counter=0, giving a seamless next frame.
  - Without acceptance in the last-bit cycle, go to IDLE; serial_out returns to IDLE_BIT and busy=0 on the next cycle.
- Latency: bit 0 of an accepted word appears on serial_out the cycle after acceptance. Each word occupies exactly WIDTH consecutive cycles.
- Throughput: one word per WIDTH cycles when data_valid is held high.
- data_ready is combinational from state and counter only. It never depends on data_valid.
- data_valid dropping mid-frame does not affect the frame in flight.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH-1 and is explicitly cleared on load.
- Reset mid-frame: the frame is discarded and outputs go to reset values immediately. No partial frame resumes after release.
- data_valid=1 during reset is ignored. The word is accepted on the first post-reset edge if still valid.

Optional Feature:
- Macro: MUX_UNMARSHALLING_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits: data bits LSB first, then one even-parity bit (XOR of the word), computed at load time.
  - data_ready in SHIFT asserts only in the parity-bit cycle.
  - frame_start is unchanged.
- Undefined: frame is WIDTH bits, with no parity logic or register present.

Decomposition:
- Shared package mux_marshalling_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - localparam DEFAULT_WIDTH=8.
  - localparam DEFAULT_IDLE_BIT=1'b0.
  - The deserializer also imports this package for DEFAULT_WIDTH.
- No sub-module: counter, shift register and FSM stay in one module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with data_valid=1 -> serial_out=0, busy=0, frame_start=0, data_ready=0. After release, data_ready=1 on the next cycle.
- Single word 8'hA5 accepted at cycle T -> serial_out over T+1..T+8 = 1,0,1,0,0,1,0,1. frame_start=1 only at T+1. busy=1 for T+1..T+8, then 0 with serial_out=0 at T+9.
- Back-to-back 8'h3C then 8'hC3 with data_valid held high -> data_ready=1 in the bit-7 cycle. 16 contiguous bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1. frame_start at bits 0 and 8 only; no idle cycle.
- Stall: data_valid=0 for 5 cycles between words -> serial_out=0, busy=0 throughout, data_ready=1; the next word starts the cycle after acceptance.
- Reset mid-frame: assert rst=0 during bit 3 of 8'hFF -> serial_out drops to 0 asynchronously. After release, no remaining bits are emitted; the next 8'h01 emits 1,0,0,0,0,0,0,0.
- With MUX_UNMARSHALLING_PARITY_EN, 8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1. data_ready only in the 9th cycle; a back-to-back second word begins at cycle 10.
